// File: rtl/keypad_time_entry_pkg.sv
// Shared definitions for the keypad time-entry controller.
// Key codes, FSM state encoding, BCD limits and two small helpers
// for the per-position digit bound and the buffer write.
package keypad_time_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EDIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  localparam logic [3:0] KEY_EDIT   = 4'hA;
  localparam logic [3:0] KEY_BACK   = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;
  localparam logic [3:0] KEY_COMMIT = 4'hD;
  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;

  localparam logic [7:0] BCD_MAX_HH = 8'h23;
  localparam logic [7:0] BCD_MAX_MM = 8'h59;
  localparam logic [7:0] BCD_MAX_SS = 8'h59;

  localparam logic [2:0] CURSOR_LAST = 3'd5;

  // Largest digit accepted at a cursor position (0 = hours tens).
  function automatic logic [3:0] digit_limit(input logic [2:0] pos);
    case (pos)
      3'd0:       return 4'd2;
      3'd2, 3'd4: return 4'd5;
      default:    return 4'd9;
    endcase
  endfunction

  // Replace the digit at cursor position pos; position 0 is the top nibble.
  function automatic logic [23:0] put_digit(input logic [23:0] buf_in,
                                            input logic [2:0]  pos,
                                            input logic [3:0]  d);
    logic [23:0] r;
    r = buf_in;
    for (int p = 0; p < 6; p++) begin
      if (pos == 3'(p)) r[20 - 4*p +: 4] = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_time_entry_if.sv
// Bus between the keypad/RTC/CLCD side and the time-entry controller.
// Key strobe, current time, write req/ack handshake and display outputs.
// Handshake: o_wr_req rises with o_wr_time valid and both hold steady until
// the cycle after i_wr_ack (a 1-cycle pulse) or the ack timeout; i_wr_ack is
// only meaningful while o_wr_req is high. i_key is qualified by i_key_valid.
// o_state exposes the controller FSM for debug.
interface keypad_time_entry_if;
  import keypad_time_entry_pkg::*;

  logic [3:0]  i_key;
  logic        i_key_valid;
  logic [23:0] i_cur_time;
  logic        i_wr_ack;
  logic        o_edit_active;
  logic [2:0]  o_cursor;
  logic [23:0] o_digits;
  logic        o_wr_req;
  logic [23:0] o_wr_time;
  logic        o_done;
  logic        o_err;
  state_t      o_state;

  modport slave (
    input  i_key, i_key_valid, i_cur_time, i_wr_ack,
    output o_edit_active, o_cursor, o_digits, o_wr_req, o_wr_time,
           o_done, o_err, o_state
  );

  modport master (
    output i_key, i_key_valid, i_cur_time, i_wr_ack,
    input  o_edit_active, o_cursor, o_digits, o_wr_req, o_wr_time,
           o_done, o_err, o_state
  );
endinterface

// File: rtl/keypad_time_entry_ms_tick_gen.sv
// 1 ms tick generator: 1-cycle o_tick every P_CNT_1MS clocks, free running.
// Ports: i_clk, i_reset_n (async active-low), o_tick.
module keypad_time_entry_ms_tick_gen #(
  parameter int P_CNT_1MS = 100_000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  output logic o_tick
);
  localparam int W = (P_CNT_1MS > 1) ? $clog2(P_CNT_1MS) : 1;
  localparam logic [W-1:0] LAST = W'(P_CNT_1MS - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_d = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;
endmodule

// File: rtl/keypad_time_entry.sv
// Keypad time-entry controller: key strobes -> 6-digit HHMMSS BCD edit
// session -> range check -> one req/ack write to the RTC controller.
// Ports: i_clk, i_reset_n (async active-low), bus (keypad_time_entry_if.slave)
// carrying key strobe, current time, write handshake and display outputs.
module keypad_time_entry
  import keypad_time_entry_pkg::*;
#(
  parameter int P_CNT_1MS         = 100_000,
  parameter int P_IDLE_TIMEOUT_MS = 10_000,
  parameter int P_ACK_TIMEOUT_MS  = 100
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  keypad_time_entry_if.slave  bus
);
  localparam int MS_MAX = (P_IDLE_TIMEOUT_MS > P_ACK_TIMEOUT_MS) ?
                          P_IDLE_TIMEOUT_MS : P_ACK_TIMEOUT_MS;
  localparam int MS_W = $clog2(MS_MAX + 1);
  localparam logic [MS_W-1:0] IDLE_LIMIT = MS_W'(P_IDLE_TIMEOUT_MS);
  localparam logic [MS_W-1:0] ACK_LIMIT  = MS_W'(P_ACK_TIMEOUT_MS);

  state_t          state_q, state_d;
  logic [23:0]     digits_q, digits_d;
  logic [2:0]      cursor_q, cursor_d;
  logic            wr_req_q, wr_req_d;
  logic [23:0]     wr_time_q, wr_time_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
  logic            ms_tick;

  logic [3:0] key;
  logic       key_valid;
  logic       is_digit, idle_expired, ack_expired, range_ok;

  keypad_time_entry_ms_tick_gen #(.P_CNT_1MS(P_CNT_1MS)) u_tick (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .o_tick   (ms_tick)
  );

  assign key          = bus.i_key;
  assign key_valid    = bus.i_key_valid;
  assign is_digit     = (key <= KEY_MAX_DIGIT);
  assign idle_expired = (ms_cnt_q == IDLE_LIMIT);
  assign ack_expired  = (ms_cnt_q == ACK_LIMIT);
  // Per-byte compare is valid BCD ordering since each nibble is <= 9.
  assign range_ok     = (digits_q[23:16] <= BCD_MAX_HH) &&
                        (digits_q[15:8]  <= BCD_MAX_MM) &&
                        (digits_q[7:0]   <= BCD_MAX_SS);

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; a strobe in EDIT takes priority over idle expiry,
  // and ack takes priority over ack timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (key_valid && key == KEY_EDIT) state_d = ST_EDIT;
      ST_EDIT: begin
        if (key_valid) begin
          if (key == KEY_CANCEL)      state_d = ST_IDLE;
          else if (key == KEY_COMMIT) state_d = ST_CHECK;
        end else if (idle_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: state_d = range_ok ? ST_WRITE : ST_EDIT;
      ST_WRITE: begin
        if (bus.i_wr_ack)     state_d = ST_IDLE;
        else if (ack_expired) state_d = ST_EDIT;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    digits_d  = digits_q;
    cursor_d  = cursor_q;
    wr_req_d  = wr_req_q;
    wr_time_d = wr_time_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_valid && key == KEY_EDIT) begin
          digits_d = bus.i_cur_time;
          cursor_d = 3'd0;
        end
      end
      ST_EDIT: begin
        if (key_valid) begin
          if (is_digit) begin
            if (key <= digit_limit(cursor_q)) begin
              digits_d = put_digit(digits_q, cursor_q, key);
              if (cursor_q != CURSOR_LAST) cursor_d = cursor_q + 3'd1;
            end else begin
              err_d = 1'b1;
            end
          end else if (key == KEY_BACK) begin
            if (cursor_q != 3'd0) cursor_d = cursor_q - 3'd1;
          end else if (key == KEY_EDIT) begin
            digits_d = bus.i_cur_time;
            cursor_d = 3'd0;
          end
        end
      end
      ST_CHECK: begin
        if (range_ok) begin
          wr_time_d = digits_q;
          wr_req_d  = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      ST_WRITE: begin
        if (bus.i_wr_ack) begin
          wr_req_d = 1'b0;
          done_d   = 1'b1;
        end else if (ack_expired) begin
          wr_req_d = 1'b0;
          err_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Shared ms-count: cleared on state change and on any strobe in EDIT,
  // only advances while a timeout is being watched.
  always_comb begin
    ms_cnt_d = ms_cnt_q;
    if (state_d != state_q)                          ms_cnt_d = '0;
    else if (state_q == ST_EDIT && key_valid)        ms_cnt_d = '0;
    else if (state_q != ST_EDIT && state_q != ST_WRITE) ms_cnt_d = '0;
    else if (ms_tick)                                ms_cnt_d = ms_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      digits_q  <= '0;
      cursor_q  <= '0;
      wr_req_q  <= 1'b0;
      wr_time_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ms_cnt_q  <= '0;
    end else begin
      digits_q  <= digits_d;
      cursor_q  <= cursor_d;
      wr_req_q  <= wr_req_d;
      wr_time_q <= wr_time_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ms_cnt_q  <= ms_cnt_d;
    end
  end

  assign bus.o_edit_active = (state_q != ST_IDLE);
  assign bus.o_cursor      = cursor_q;
  assign bus.o_digits      = digits_q;
  assign bus.o_wr_req      = wr_req_q;
  assign bus.o_wr_time     = wr_time_q;
  assign bus.o_done        = done_q;
  assign bus.o_err         = err_q;
  assign bus.o_state       = state_q;
endmodule

// File: tb/tb_keypad_time_entry.sv
// Directed bench for keypad_time_entry with hand-computed expectations.
module tb_keypad_time_entry;
  import keypad_time_entry_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  keypad_time_entry_if bus();

  keypad_time_entry #(
    .P_CNT_1MS        (10),
    .P_IDLE_TIMEOUT_MS(5),
    .P_ACK_TIMEOUT_MS (3)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drivers: called at a negedge, return at the next negedge
  task automatic press(input logic [3:0] k);
    bus.i_key       = k;
    bus.i_key_valid = 1'b1;
    @(negedge clk);
    bus.i_key_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_seq(input logic [3:0] keys[$]);
    foreach (keys[i]) press(keys[i]);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    bit  err_seen;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.i_key = 4'h0;
    bus.i_key_valid = 1'b0;
    bus.i_cur_time = 24'h120000;
    bus.i_wr_ack = 1'b0;

    #3;
    check("rst_edit_active", 32'(bus.o_edit_active), 0);
    check("rst_wr_req",      32'(bus.o_wr_req), 0);
    check("rst_digits",      32'(bus.o_digits), 0);
    check("rst_state",       32'(bus.o_state), 32'(ST_IDLE));
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(2);

    // 1 Happy path
    press(4'hA);
    check("t1_edit_active", 32'(bus.o_edit_active), 1);
    check("t1_load",        32'(bus.o_digits), 32'h120000);
    check("t1_cursor0",     32'(bus.o_cursor), 0);
    press_seq('{4'd2, 4'd3, 4'd5, 4'd9, 4'd4, 4'd8});
    check("t1_digits",      32'(bus.o_digits), 32'h235948);
    check("t1_cursor5",     32'(bus.o_cursor), 5);
    press(4'hD);
    check("t1_req_not_yet", 32'(bus.o_wr_req), 0);
    @(negedge clk);
    check("t1_req",         32'(bus.o_wr_req), 1);
    check("t1_wr_time",     32'(bus.o_wr_time), 32'h235948);
    check("t1_state_write", 32'(bus.o_state), 32'(ST_WRITE));
    // keys during WRITE are ignored (fills the 4-cycle ack delay)
    press(4'hC);
    press(4'hA);
    press(4'd5);
    check("t6_wr_keys_state",  32'(bus.o_state), 32'(ST_WRITE));
    check("t6_wr_keys_req",    32'(bus.o_wr_req), 1);
    check("t6_wr_keys_digits", 32'(bus.o_digits), 32'h235948);
    check("t6_wr_keys_cursor", 32'(bus.o_cursor), 5);
    bus.i_wr_ack = 1'b1;
    @(negedge clk);
    bus.i_wr_ack = 1'b0;
    check("t1_done",        32'(bus.o_done), 1);
    check("t1_req_drop",    32'(bus.o_wr_req), 0);
    check("t1_idle",        32'(bus.o_edit_active), 0);
    check("t1_no_err",      32'(bus.o_err), 0);
    @(negedge clk);
    check("t1_done_pulse",  32'(bus.o_done), 0);
    // ack while IDLE
    bus.i_wr_ack = 1'b1;
    @(negedge clk);
    bus.i_wr_ack = 1'b0;
    check("t6_ack_idle_done",  32'(bus.o_done), 0);
    check("t6_ack_idle_state", 32'(bus.o_state), 32'(ST_IDLE));
    press(4'd7);
    check("t6_idle_digit",     32'(bus.o_state), 32'(ST_IDLE));

    // 2 Digit bounds
    press(4'hA);
    press(4'd3);
    check("t2_err_pos0",    32'(bus.o_err), 1);
    check("t2_cursor_pos0", 32'(bus.o_cursor), 0);
    check("t2_digits_rej",  32'(bus.o_digits), 32'h120000);
    press(4'd2);
    check("t2_err_clear",   32'(bus.o_err), 0);
    check("t2_cursor1",     32'(bus.o_cursor), 1);
    check("t2_digits_acc",  32'(bus.o_digits), 32'h220000);
    press(4'd0);
    press(4'd6);
    check("t2_err_pos2",    32'(bus.o_err), 1);
    check("t2_cursor_pos2", 32'(bus.o_cursor), 2);
    check("t2_digits_pos2", 32'(bus.o_digits), 32'h200000);
    press(4'hC);
    check("t2_cancel_state", 32'(bus.o_state), 32'(ST_IDLE));
    check("t2_cancel_keep",  32'(bus.o_digits), 32'h200000);

    // 3 Range check failure and back-space saturation
    press(4'hA);
    press_seq('{4'd2, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0});
    check("t3_digits", 32'(bus.o_digits), 32'h290000);
    press(4'hD);
    @(negedge clk);
    check("t3_err",        32'(bus.o_err), 1);
    check("t3_state_edit", 32'(bus.o_state), 32'(ST_EDIT));
    check("t3_no_req",     32'(bus.o_wr_req), 0);
    check("t3_cursor",     32'(bus.o_cursor), 5);
    check("t3_digits_kept", 32'(bus.o_digits), 32'h290000);
    press_seq('{4'hB, 4'hB, 4'hB, 4'hB, 4'hB});
    check("t3_back_cursor0", 32'(bus.o_cursor), 0);
    press(4'hB);
    check("t3_back_sat",     32'(bus.o_cursor), 0);
    check("t3_back_digits",  32'(bus.o_digits), 32'h290000);
    press(4'hC);

    // 4 Cursor saturation
    press(4'hA);
    press_seq('{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7});
    check("t4_cursor_sat", 32'(bus.o_cursor), 5);
    check("t4_overwrite",  32'(bus.o_digits), 32'h123457);

    // 5a Idle timeout in EDIT
    err_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.o_err) err_seen = 1'b1;
    end
    check("t5_edit_before_to", 32'(bus.o_state), 32'(ST_EDIT));
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_err) err_seen = 1'b1;
      if (bus.o_state == ST_IDLE) seen = 1'b1;
    end
    check("t5_idle_timeout",  32'(seen), 1);
    check("t5_idle_no_err",   32'(err_seen), 0);
    check("t5_idle_inactive", 32'(bus.o_edit_active), 0);

    // 5b Ack timeout in WRITE
    press(4'hA);
    press(4'hD);
    @(negedge clk);
    check("t5_req_up", 32'(bus.o_wr_req), 1);
    seen = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.o_err) seen = 1'b1;
    end
    check("t5_ack_to_err",    32'(seen), 1);
    check("t5_ack_to_window", 32'(cyc >= 20 && cyc <= 32), 1);
    check("t5_ack_to_req",    32'(bus.o_wr_req), 0);
    check("t5_ack_to_edit",   32'(bus.o_state), 32'(ST_EDIT));
    check("t5_ack_to_done",   32'(bus.o_done), 0);

    // 5c Strobe in the idle-expiry cycle keeps EDIT
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (int'(dut.ms_cnt_q) == 5 && bus.o_state == ST_EDIT) seen = 1'b1;
      else @(negedge clk);
    end
    check("t5_expiry_found", 32'(seen), 1);
    press(4'hE);
    check("t5_expiry_key_wins", 32'(bus.o_state), 32'(ST_EDIT));
    check("t5_expiry_no_err",   32'(bus.o_err), 0);
    idle_cycles(30);
    check("t5_expiry_timer_clr", 32'(bus.o_state), 32'(ST_EDIT));
    press(4'hC);

    // 6 Reset mid-WRITE drops everything without a clock edge
    press(4'hA);
    press(4'hD);
    @(negedge clk);
    check("t6_req_up", 32'(bus.o_wr_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_req",    32'(bus.o_wr_req), 0);
    check("t6_rst_active", 32'(bus.o_edit_active), 0);
    check("t6_rst_digits", 32'(bus.o_digits), 0);
    check("t6_rst_wtime",  32'(bus.o_wr_time), 0);
    check("t6_rst_cursor", 32'(bus.o_cursor), 0);
    check("t6_rst_state",  32'(bus.o_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
